// File: rtl/multi_bird_renderer.sv
// Renders up to NUM_BIRDS 13-pixel bird sprites per frame: an erase pass at the old position,
// then a draw pass at the new one, for each bird in turn. Pixels come out through a two-stage pipeline.
module multi_bird_renderer #(
   parameter int         NUM_BIRDS   = 2,
   parameter int         X_MAX       = 160,
   parameter int         Y_MAX       = 120,
   parameter logic [2:0] BIRD_COLOUR = 3'b111,
   parameter logic [2:0] BG_COLOUR   = 3'b000
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   frame_tick,
   input  logic [NUM_BIRDS-1:0]   bird_active,
   input  logic [8*NUM_BIRDS-1:0] bird_x,
   input  logic [7*NUM_BIRDS-1:0] bird_y,
   output logic [7:0]             x_out,
   output logic [6:0]             y_out,
   output logic [2:0]             colour_out,
   output logic                   plot,
   output logic                   busy,
   output logic                   frame_done,
   output logic                   overrun
);

   localparam int BW = (NUM_BIRDS > 1) ? $clog2(NUM_BIRDS) : 1;
   localparam logic signed [8:0] X_LIM = 9'(X_MAX);
   localparam logic signed [7:0] Y_LIM = 8'(Y_MAX);

   typedef enum logic [1:0] {IDLE, ERASE, DRAW, DONE} state_t;

   state_t                 state_reg, state_next;
   logic [BW-1:0]          b_reg, b_next;
   logic [3:0]             p_reg, p_next;
   logic [NUM_BIRDS-1:0]   snap_active_w, drawn_w;
   logic [8*NUM_BIRDS-1:0] snap_x_w, prev_x_w;
   logic [7*NUM_BIRDS-1:0] snap_y_w, prev_y_w;
   logic signed [8:0]      s1_x_reg;
   logic signed [7:0]      s1_y_reg;
   logic [2:0]             s1_colour_reg;
   logic                   s1_valid_reg, s1_done_reg;
   logic                   plot_reg, busy_reg, frame_done_reg, overrun_reg;
   logic [7:0]             x_out_reg;
   logic [6:0]             y_out_reg;
   logic [2:0]             colour_out_reg;
   logic                   accept, last_pixel, last_bird, pix_on, in_bounds;
   logic [7:0]             cur_x;
   logic [6:0]             cur_y;
   logic signed [3:0]      dx, dy;
   logic signed [8:0]      pix_x;
   logic signed [7:0]      pix_y;

   // Sprite offsets relative to the head, pixel 0 being the head itself.
   always_comb begin
      dx = 4'sd0;
      dy = 4'sd0;
      case (p_reg)
         4'd1:  dy = 4'sd1;
         4'd2:  dx = -4'sd1;
         4'd3:  dx = -4'sd2;
         4'd4:  dx = -4'sd3;
         4'd5:  dx = -4'sd4;
         4'd6:  dx = -4'sd5;
         4'd7:  begin dx = -4'sd3; dy = 4'sd1;  end
         4'd8:  begin dx = -4'sd3; dy = -4'sd1; end
         4'd9:  begin dx = -4'sd4; dy = 4'sd2;  end
         4'd10: begin dx = -4'sd4; dy = -4'sd2; end
         4'd11: begin dx = -4'sd5; dy = 4'sd3;  end
         4'd12: begin dx = -4'sd5; dy = -4'sd3; end
         default: ;
      endcase
   end

   assign accept     = (state_reg == IDLE) && frame_tick && !busy_reg && !frame_done_reg;
   assign last_pixel = (p_reg == 4'd12);
   assign last_bird  = (b_reg == BW'(NUM_BIRDS - 1));

   genvar gi;
   generate
      for (gi = 0; gi < NUM_BIRDS; gi++) begin : g_bird
         logic       snap_active_reg, drawn_reg;
         logic [7:0] snap_x_reg, prev_x_reg;
         logic [6:0] snap_y_reg, prev_y_reg;
         always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
               snap_active_reg <= 1'b0;
               snap_x_reg      <= '0;
               snap_y_reg      <= '0;
               drawn_reg       <= 1'b0;
               prev_x_reg      <= '0;
               prev_y_reg      <= '0;
            end else begin
               if (accept) begin
                  snap_active_reg <= bird_active[gi];
                  snap_x_reg      <= bird_x[8*gi +: 8];
                  snap_y_reg      <= bird_y[7*gi +: 7];
               end
               if (state_reg == DRAW && last_pixel && b_reg == BW'(gi)) begin
                  drawn_reg  <= snap_active_reg;
                  prev_x_reg <= snap_x_reg;
                  prev_y_reg <= snap_y_reg;
               end
            end
         end
         assign snap_active_w[gi]    = snap_active_reg;
         assign drawn_w[gi]          = drawn_reg;
         assign snap_x_w[8*gi +: 8]  = snap_x_reg;
         assign prev_x_w[8*gi +: 8]  = prev_x_reg;
         assign snap_y_w[7*gi +: 7]  = snap_y_reg;
         assign prev_y_w[7*gi +: 7]  = prev_y_reg;
      end
   endgenerate

   always_comb begin
      state_next = state_reg;
      b_next     = b_reg;
      p_next     = p_reg;
      case (state_reg)
         IDLE: if (accept) begin
            state_next = ERASE;
            b_next     = '0;
            p_next     = '0;
         end
         ERASE: begin
            p_next = last_pixel ? 4'd0 : p_reg + 4'd1;
            if (last_pixel) state_next = DRAW;
         end
         DRAW: begin
            p_next = last_pixel ? 4'd0 : p_reg + 4'd1;
            if (last_pixel) begin
               if (last_bird) state_next = DONE;
               else begin
                  state_next = ERASE;
                  b_next     = b_reg + 1'b1;
               end
            end
         end
         DONE: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Erase uses the remembered position, draw uses the frame snapshot.
   assign cur_x  = (state_reg == ERASE) ? prev_x_w[8*b_reg +: 8] : snap_x_w[8*b_reg +: 8];
   assign cur_y  = (state_reg == ERASE) ? prev_y_w[7*b_reg +: 7] : snap_y_w[7*b_reg +: 7];
   assign pix_on = ((state_reg == ERASE) && drawn_w[b_reg]) ||
                   ((state_reg == DRAW) && snap_active_w[b_reg]);
   assign pix_x  = $signed({1'b0, cur_x}) + {{5{dx[3]}}, dx};
   assign pix_y  = $signed({1'b0, cur_y}) + {{4{dy[3]}}, dy};
   assign in_bounds = !s1_x_reg[8] && (s1_x_reg < X_LIM) && !s1_y_reg[7] && (s1_y_reg < Y_LIM);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_reg      <= IDLE;
         b_reg          <= '0;
         p_reg          <= '0;
         s1_x_reg       <= '0;
         s1_y_reg       <= '0;
         s1_colour_reg  <= '0;
         s1_valid_reg   <= 1'b0;
         s1_done_reg    <= 1'b0;
         plot_reg       <= 1'b0;
         busy_reg       <= 1'b0;
         frame_done_reg <= 1'b0;
         overrun_reg    <= 1'b0;
         x_out_reg      <= '0;
         y_out_reg      <= '0;
         colour_out_reg <= '0;
      end else begin
         state_reg      <= state_next;
         b_reg          <= b_next;
         p_reg          <= p_next;
         s1_x_reg       <= pix_x;
         s1_y_reg       <= pix_y;
         s1_colour_reg  <= (state_reg == ERASE) ? BG_COLOUR : BIRD_COLOUR;
         s1_valid_reg   <= pix_on;
         s1_done_reg    <= (state_reg == DONE);
         plot_reg       <= s1_valid_reg && in_bounds;
         if (s1_valid_reg && in_bounds) begin
            x_out_reg      <= s1_x_reg[7:0];
            y_out_reg      <= s1_y_reg[6:0];
            colour_out_reg <= s1_colour_reg;
         end
         // busy and frame_done follow the pipeline so they line up with the last pixel out.
         frame_done_reg <= s1_done_reg;
         if (accept) busy_reg <= 1'b1;
         else if (s1_done_reg) busy_reg <= 1'b0;
         if (frame_tick && (busy_reg || frame_done_reg)) overrun_reg <= 1'b1;
      end
   end

   assign x_out      = x_out_reg;
   assign y_out      = y_out_reg;
   assign colour_out = colour_out_reg;
   assign plot       = plot_reg;
   assign busy       = busy_reg;
   assign frame_done = frame_done_reg;
   assign overrun    = overrun_reg;

endmodule

// File: doc/multi_bird_renderer.md
MULTI_BIRD_RENDERER -- requirements
Module: multi_bird_renderer

Interface
REQ-001 Parameter NUM_BIRDS, default 2: number of bird channels, legal range 1..8.
REQ-002 Parameter X_MAX, default 160: screen width in pixels.
REQ-003 Parameter Y_MAX, default 120: screen height in pixels.
REQ-004 Parameter BIRD_COLOUR, default 3'b111: colour for draw passes.
REQ-005 Parameter BG_COLOUR, default 3'b000: colour for erase passes.
REQ-006 clock  in  1: single clock for all logic.
REQ-007 reset  in  1: asynchronous, active-high reset.
REQ-008 frame_tick  in  1: one-cycle pulse requesting a redraw of all birds.
REQ-009 bird_active  in  NUM_BIRDS: per-bird enable; bit i belongs to bird i.
REQ-010 bird_x  in  8*NUM_BIRDS: packed head x positions; bird i uses bits [8i+7:8i].
REQ-011 bird_y  in  7*NUM_BIRDS: packed head y positions; bird i uses bits [7i+6:7i].
REQ-012 x_out  out  8: pixel x coordinate for the VGA adapter.
REQ-013 y_out  out  7: pixel y coordinate.
REQ-014 colour_out  out  3: pixel colour.
REQ-015 plot  out  1: write strobe for the current pixel.
REQ-016 busy  out  1: high while a frame sequence is running.
REQ-017 frame_done  out  1: one-cycle pulse when a frame sequence completes.
REQ-018 overrun  out  1: sticky flag set when frame_tick arrives while busy.

Function
REQ-019 The sprite SHALL be 13 pixels, indexed 0..12, at (dx,dy) offsets from the head: (0,0) (0,+1) (-1,0) (-2,0) (-3,0) (-4,0) (-5,0) (-3,+1) (-3,-1) (-4,+2) (-4,-2) (-5,+3) (-5,-3).
REQ-020 States SHALL be IDLE, ERASE, DRAW, DONE; the FSM SHALL hold a bird index b (0..NUM_BIRDS-1) and a pixel index p (0..12).
REQ-021 In IDLE, a rising edge with frame_tick=1 SHALL snapshot bird_active, bird_x and bird_y, set b=0 and p=0, raise busy, and enter ERASE.
REQ-022 Each ERASE pass and each DRAW pass SHALL last exactly 13 cycles, one pixel per cycle, whether or not any pixel is plotted.
REQ-023 Pass order SHALL be: ERASE b, DRAW b, then ERASE b+1; after DRAW of bird NUM_BIRDS-1 the FSM SHALL enter DONE, then IDLE on the next edge.
REQ-024 An ERASE pass SHALL use the stored previous position of bird b and BG_COLOUR; plot SHALL be 0 for the whole pass if bird b's drawn flag is 0.
REQ-025 A DRAW pass SHALL use the snapshot position of bird b and BIRD_COLOUR; plot SHALL be 0 for the whole pass if the snapshot active bit is 0.
REQ-026 At the end of DRAW b, the stored position SHALL take the snapshot position and the drawn flag SHALL take the snapshot active bit.
REQ-027 Pixel coordinates SHALL be computed signed with one extra bit; a pixel with x<0, x>=X_MAX, y<0 or y>=Y_MAX SHALL be output with plot=0 (clipped, no wrap-around).
REQ-028 x_out, y_out, colour_out and plot SHALL be registered, so that pixel p of the first pass appears after the second rising edge following the edge that accepted frame_tick.
REQ-029 When plot=0, x_out, y_out and colour_out SHALL hold their last values.
REQ-030 frame_done SHALL pulse during the DONE cycle, which immediately follows the output cycle of the last pixel; busy SHALL fall on that same edge.
REQ-031 Total frame length SHALL be 26*NUM_BIRDS pixel cycles.
REQ-032 A frame_tick arriving while busy=1 SHALL be ignored and SHALL set overrun, which stays high until reset.
REQ-033 A frame_tick arriving in the DONE cycle SHALL also count as an overrun.
REQ-034 Changes to the bird inputs during busy SHALL have no effect on the current frame.

Reset
REQ-035 Asserting reset at any time, including mid-frame, SHALL force the FSM to IDLE with b=0 and p=0.
REQ-036 Reset SHALL set plot, busy, frame_done and overrun to 0, and x_out, y_out and colour_out to 0.
REQ-037 Reset SHALL clear all drawn flags and stored positions; the first frame after reset therefore performs no visible erase.
REQ-038 Pixels already written to the frame buffer are not cleaned up by reset.

Verification
REQ-039 With NUM_BIRDS=2, bird0 active at (50,60), bird1 inactive, issue a tick -> ERASE0 plots nothing, DRAW0 plots exactly the 13 sprite pixels at colour 111 (first pixel (50,60), last (45,57)), pass 2 and pass 3 plot nothing, frame_done after 52 pixel cycles.
REQ-040 Issue a second tick with bird0 at (51,60) -> ERASE0 plots 13 pixels at colour 000 around (50,60), then DRAW0 plots around (51,60).
REQ-041 Bird0 at (2,1), tick -> only pixels 0, 1, 2 and 3 are plotted; the rest are clipped because x or y goes negative.
REQ-042 Issue a tick, then a second tick 10 cycles later -> the second tick is ignored, overrun=1, the frame still ends after 52 pixel cycles, and overrun stays 1 afterwards.
REQ-043 Apply reset at pixel 5 of DRAW0 -> next cycle plot=0, busy=0; on the following tick ERASE0 plots nothing.
REQ-044 With NUM_BIRDS=8, all birds active, change bird_x during busy -> the output matches the snapshot positions, with 208 pixel cycles per frame.
